ysyx_25040101_lsu: RTL
======================

Name: ysyx_25040101_lsu

Overview:
Multi-cycle load/store unit. It consumes the one-hot memory-op enables produced by the instruction decoder and drives an AXI4-Lite master port. It stalls the core until the bus transaction completes, then returns load data that has already been lane-extracted and extended. It sits between the decoder/ALU address path and the data-memory bus, and replaces the combinational memory access path.

Parameters:
TIMEOUT_CYC, 1024, bus-response watchdog in cycles; 0 disables it.
AW, 32, address width. Data width is fixed at 32.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  current instruction valid
addr_i  in  AW  effective byte address (ALU result)
wdata_i  in  32  store data (rs2)
read_1B_mem_en_i / read_2B_mem_en_i / read_2B_sext_mem_en_i / read_4B_mem_en_i  in  1 each  lbu / lhu / lh / lw
write_1B_mem_en_i / write_2B_mem_en_i / write_4B_mem_en_i  in  1 each  sb / sh / sw
stall_o  out  1  hold PC and register write
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: misaligned, multi-op, bus error or timeout
rdata_o  out  32  extended load data; valid with done_o
araddr_o AW, arvalid_o 1 out; arready_i 1 in
rdata_i 32, rresp_i 2, rvalid_i 1 in; rready_o 1 out
awaddr_o AW, awvalid_o 1, wdata_o 32, wstrb_o 4, wvalid_o 1 out; awready_i 1, wready_i 1 in
bresp_i 2, bvalid_i 1 in; bready_o 1 out

Behaviour:
- Reset: state=IDLE. All valid/ready outputs, done_o, err_o and stall_o are 0; rdata_o, araddr_o, awaddr_o, wdata_o and wstrb_o are 0. Watchdog counter is 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Start condition: valid_i && (any enable) && !done_o, evaluated in IDLE only. The !done_o term blocks re-issue of the same instruction in the completion cycle.
- stall_o = (state!=IDLE) || start (combinational). It is 0 in the done_o cycle, and the core advances on that cycle.
- Illegal start: more than one enable set, or misalignment (4B with addr[1:0]!=0, 2B with addr[0]!=0). No bus activity occurs. The next cycle has done_o=1, err_o=1 and rdata_o=0.
- Legal read start: registers araddr={addr[AW-1:2],2'b00}, arvalid=1, latches offset and op type, goes to RD_ADDR.
- RD_ADDR: on arvalid&&arready, drops arvalid, raises rready, goes to RD_DATA.
- RD_DATA: on rvalid&&rready, drops rready. Data is shifted right by 8*offset, then extended: lbu zero-extends [7:0], lhu zero-extends [15:0], lh sign-extends [15:0], lw is unmodified. The result is registered into rdata_o. err = (rresp!=0). The next cycle is IDLE with done_o=1.
- Legal write start: awaddr is word-aligned, and wdata_o = wdata_i << 8*offset. wstrb is 4'b0001<<off (1B), 4'b0011<<off (2B) or 4'b1111 (4B). awvalid=wvalid=1, goes to WR_REQ.
- WR_REQ: AW and W complete independently. Each valid drops on its own handshake, which may occur in the same cycle or in either order. When both are done, bready=1 and the unit goes to WR_RESP.
- WR_RESP: on bvalid&&bready, drops bready. err = (bresp!=0). The next cycle is IDLE with done_o=1 and rdata_o=0.
- Output stability: address, data and strobe are held stable while their valid is high.
- Watchdog: the counter increments every cycle outside IDLE and clears on entering IDLE. At count == TIMEOUT_CYC-1 (when TIMEOUT_CYC != 0), all valids/readies drop and the unit returns to IDLE with done_o=1 and err_o=1. This is a simulation guard; the bus slave must be reset afterward.
- Reset mid-operation: the unit returns to IDLE on the next edge and the outstanding transaction is abandoned. The slave shares rst_i.
- Input sampling: inputs are sampled only at start, so later changes to addr_i/wdata_i are ignored.

Decomposition:
- Shared package ysyx_25040101_lsu_pkg: state encoding; AXI resp constants (OKAY=2'b00); op-size encoding (SZ_B, SZ_H, SZ_W).
- Sub-module ysyx_25040101_lsu_lane (combinational): wstrb/wdata alignment and load extraction/extension. It is unit-testable on its own.

Test Plan:
- lw at 0x8000_0004, arready immediate, rvalid 2 cycles later with 0xDEAD_BEEF -> araddr=0x8000_0004; done_o 1 cycle after the R handshake; rdata_o=0xDEAD_BEEF, err_o=0; stall_o high for 4 cycles.
- lbu at 0x...03 and lh at 0x...02 with bus word 0x80FF_1234 -> lbu rdata_o=0x0000_0080, lh rdata_o=0xFFFF_80FF.
- sb 0xAB at 0x...01 with awready 3 cycles before wready -> wstrb=4'b0010, wdata=0x0000_AB00; bready raised only after both handshakes; bresp=0 -> err_o=0.
- sw at 0x...02 -> no arvalid/awvalid ever; next cycle done_o=1, err_o=1. Asserting both read_4B and write_4B also gives err_o=1.
- sh with bresp=2'b10 -> done_o=1, err_o=1. Separately, TIMEOUT_CYC=8 with a silent slave -> done_o and err_o at cycle 8.
- rst_i asserted in RD_DATA -> next cycle IDLE, all outputs 0. A fresh lw after reset completes normally.

Source files
------------

// File: rtl/ysyx_25040101_lsu_pkg.sv
// Shared types for the LSU: FSM states, access sizes, AXI response codes.
// Also holds the misalignment rule used at issue time.
package ysyx_25040101_lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_RESP = 3'd4
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_lane.sv
// Byte-lane steering: store strobe/data alignment and load extraction/extension.
// Purely combinational, no handshake.
import ysyx_25040101_lsu_pkg::*;

module ysyx_25040101_lsu_lane (
   input  lsu_size_e   size_i,
   input  logic        sext_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_word_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);

   logic [4:0]  sh_amt;
   logic [31:0] ld_shift;

   assign sh_amt   = {off_i, 3'b000};
   assign wdata_o  = st_data_i << sh_amt;
   assign ld_shift = ld_word_i >> sh_amt;

   always_comb begin
      wstrb_o = 4'b0000;
      case (size_i)
         SZ_B:    wstrb_o = 4'b0001 << off_i;
         SZ_H:    wstrb_o = 4'b0011 << off_i;
         SZ_W:    wstrb_o = 4'b1111;
         default: wstrb_o = 4'b0000;
      endcase
   end

   always_comb begin
      ld_data_o = ld_shift;
      case (size_i)
         SZ_B:    ld_data_o = {24'h0, ld_shift[7:0]};
         SZ_H:    ld_data_o = sext_i ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                     : {16'h0, ld_shift[15:0]};
         default: ld_data_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Multi-cycle load/store unit with an AXI4-Lite master; stalls the core until
// the bus responds, then pulses done_o with extended load data one cycle later.
import ysyx_25040101_lsu_pkg::*;

module ysyx_25040101_lsu #(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned AW          = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   input  logic          read_1B_mem_en_i,
   input  logic          read_2B_mem_en_i,
   input  logic          read_2B_sext_mem_en_i,
   input  logic          read_4B_mem_en_i,
   input  logic          write_1B_mem_en_i,
   input  logic          write_2B_mem_en_i,
   input  logic          write_4B_mem_en_i,
   output logic          stall_o,
   output logic          done_o,
   output logic          err_o,
   output logic [31:0]   rdata_o,
   output logic [AW-1:0] araddr_o,
   output logic          arvalid_o,
   input  logic          arready_i,
   input  logic [31:0]   rdata_i,
   input  logic [1:0]    rresp_i,
   input  logic          rvalid_i,
   output logic          rready_o,
   output logic [AW-1:0] awaddr_o,
   output logic          awvalid_o,
   output logic [31:0]   wdata_o,
   output logic [3:0]    wstrb_o,
   output logic          wvalid_o,
   input  logic          awready_i,
   input  logic          wready_i,
   input  logic [1:0]    bresp_i,
   input  logic          bvalid_i,
   output logic          bready_o
);

   localparam logic [31:0] WD_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

   lsu_state_e    state_q, state_d;
   lsu_size_e     size_q, size_d;
   logic          sext_q, sext_d;
   logic [1:0]    off_q, off_d;
   logic [AW-1:0] araddr_q, araddr_d;
   logic [AW-1:0] awaddr_q, awaddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          bready_q, bready_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   wdog_q, wdog_d;

   logic [6:0]    en_vec;
   logic          any_en, multi_en, is_rd, start, bad;
   lsu_size_e     st_size;
   lsu_size_e     lane_size;
   logic [1:0]    lane_off;
   logic [3:0]    lane_wstrb;
   logic [31:0]   lane_wdata, lane_ld;

   assign en_vec = {write_4B_mem_en_i, write_2B_mem_en_i, write_1B_mem_en_i,
                    read_4B_mem_en_i, read_2B_sext_mem_en_i, read_2B_mem_en_i,
                    read_1B_mem_en_i};
   assign any_en   = |en_vec;
   assign multi_en = |(en_vec & (en_vec - 7'd1));
   assign is_rd    = |en_vec[3:0];

   always_comb begin
      st_size = SZ_B;
      if (read_4B_mem_en_i || write_4B_mem_en_i) begin
         st_size = SZ_W;
      end else if (read_2B_mem_en_i || read_2B_sext_mem_en_i || write_2B_mem_en_i) begin
         st_size = SZ_H;
      end
   end

   // !done_q keeps the just-completed instruction from issuing a second time.
   assign start = (state_q == S_IDLE) && valid_i && any_en && !done_q;
   assign bad   = multi_en || misaligned(st_size, addr_i[1:0]);

   // Store alignment is needed at issue (IDLE), load extraction later from latched op.
   assign lane_size = (state_q == S_IDLE) ? st_size : size_q;
   assign lane_off  = (state_q == S_IDLE) ? addr_i[1:0] : off_q;

   ysyx_25040101_lsu_lane u_lane (
      .size_i    (lane_size),
      .sext_i    (sext_q),
      .off_i     (lane_off),
      .st_data_i (wdata_i),
      .ld_word_i (rdata_i),
      .wstrb_o   (lane_wstrb),
      .wdata_o   (lane_wdata),
      .ld_data_o (lane_ld)
   );

   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      sext_d    = sext_q;
      off_d     = off_q;
      araddr_d  = araddr_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wdog_d    = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else begin
                  off_d  = addr_i[1:0];
                  size_d = st_size;
                  sext_d = read_2B_sext_mem_en_i;
                  if (is_rd) begin
                     araddr_d  = {addr_i[AW-1:2], 2'b00};
                     arvalid_d = 1'b1;
                     state_d   = S_RD_ADDR;
                  end else begin
                     awaddr_d  = {addr_i[AW-1:2], 2'b00};
                     wdata_d   = lane_wdata;
                     wstrb_d   = lane_wstrb;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     state_d   = S_WR_REQ;
                  end
               end
            end
         end
         S_RD_ADDR: begin
            if (arvalid_q && arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rvalid_i && rready_q) begin
               rready_d = 1'b0;
               rdata_d  = lane_ld;
               err_d    = (rresp_i != RESP_OKAY);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_WR_REQ: begin
            // AW and W retire independently; B is only accepted once both have.
            if (awready_i) awvalid_d = 1'b0;
            if (wready_i)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (bvalid_i && bready_q) begin
               bready_d = 1'b0;
               rdata_d  = 32'h0;
               err_d    = (bresp_i != RESP_OKAY);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE) begin
         if (state_d != S_IDLE) wdog_d = wdog_q + 32'd1;
         if ((TIMEOUT_CYC != 0) && (wdog_q == WD_LAST)) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            rdata_d   = 32'h0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            wdog_d    = 32'd0;
            state_d   = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         size_q    <= SZ_B;
         sext_q    <= 1'b0;
         off_q     <= 2'b00;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'h0;
         wdog_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         sext_q    <= sext_d;
         off_q     <= off_d;
         araddr_q  <= araddr_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         wdog_q    <= wdog_d;
      end
   end

   assign stall_o   = (state_q != S_IDLE) || start;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign rdata_o   = rdata_q;
   assign araddr_o  = araddr_q;
   assign arvalid_o = arvalid_q;
   assign rready_o  = rready_q;
   assign awaddr_o  = awaddr_q;
   assign awvalid_o = awvalid_q;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = wstrb_q;
   assign wvalid_o  = wvalid_q;
   assign bready_o  = bready_q;

endmodule
